// File: rtl/medidor_timer.sv
`default_nettype none
// ============================================================================
// Module   : medidor_timer
// Purpose  : Measures the high (on) and low (interval) phase lengths of the
//            entrada pulse train in ticks of CLK_DIV clk cycles. It publishes
//            one result pair per complete period, with a one-cycle strobe.
// Option   : MEDIDOR_TIMEOUT_EN enables stuck-line detection (sem_sinal).
// Revision : 1.0 - initial release
// ============================================================================
module medidor_timer #(
  parameter int CLK_DIV = 1000,
  parameter int W       = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         entrada,
  output logic [W-1:0] tempo_medido,
  output logic [W-1:0] intervalo_medido,
  output logic         valido,
  output logic         estouro,
  output logic         sem_sinal
);

  localparam logic [1:0]   ST_ESPERA     = 2'd0;
  localparam logic [1:0]   ST_MEDE_ALTO  = 2'd1;
  localparam logic [1:0]   ST_MEDE_BAIXO = 2'd2;
  localparam logic [15:0]  PRE_MAX       = 16'(CLK_DIV - 1);
  localparam logic [W-1:0] CNT_MAX       = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE       = {{(W-1){1'b0}}, 1'b1};

  logic         sync1_q, sync2_q, hist_q;
  logic [1:0]   state_q, state_d;
  logic [15:0]  pre_q, pre_d, pre_cur;
  logic [W-1:0] cnt_q, cnt_d, alto_q, alto_d;
  logic         sat_q, sat_d, sat_alto_q, sat_alto_d;
  logic [W-1:0] tempo_q, tempo_d, intervalo_q, intervalo_d;
  logic         valido_q, valido_d, estouro_q, estouro_d;
  logic         rise, fall, edge_det, tick, timeout;

  assign rise     = sync2_q & ~hist_q;
  assign fall     = ~sync2_q & hist_q;
  assign edge_det = rise | fall;

  // The edge cycle itself counts as prescaler position 0, so a phase of
  // N cycles yields floor(N/CLK_DIV) ticks before the closing edge.
  assign pre_cur = edge_det ? 16'd0 : pre_q;
  assign tick    = ~edge_det && (pre_q == PRE_MAX) && (state_q != ST_ESPERA);

`ifdef MEDIDOR_TIMEOUT_EN
  assign timeout = tick && (cnt_q == CNT_MAX) && sat_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      hist_q      <= 1'b1;
      state_q     <= ST_ESPERA;
      pre_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      alto_q      <= '0;
      sat_alto_q  <= 1'b0;
      tempo_q     <= '0;
      intervalo_q <= '0;
      valido_q    <= 1'b0;
      estouro_q   <= 1'b0;
    end else begin
      sync1_q     <= entrada;
      sync2_q     <= sync1_q;
      hist_q      <= sync2_q;
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      alto_q      <= alto_d;
      sat_alto_q  <= sat_alto_d;
      tempo_q     <= tempo_d;
      intervalo_q <= intervalo_d;
      valido_q    <= valido_d;
      estouro_q   <= estouro_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ESPERA: begin
        if (rise) state_d = ST_MEDE_ALTO;
      end
      ST_MEDE_ALTO: begin
        if (fall)         state_d = ST_MEDE_BAIXO;
        else if (timeout) state_d = ST_ESPERA;
      end
      ST_MEDE_BAIXO: begin
        if (rise)         state_d = ST_MEDE_ALTO;
        else if (timeout) state_d = ST_ESPERA;
      end
      default: state_d = ST_ESPERA;
    endcase
  end

  always_comb begin
    pre_d       = (pre_cur == PRE_MAX) ? 16'd0 : pre_cur + 16'd1;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    alto_d      = alto_q;
    sat_alto_d  = sat_alto_q;
    tempo_d     = tempo_q;
    intervalo_d = intervalo_q;
    estouro_d   = estouro_q;
    valido_d    = 1'b0;

    if (edge_det) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (tick) begin
      if (cnt_q == CNT_MAX) sat_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_ONE;
    end

    if (((state_q == ST_ESPERA) && !rise) || timeout) begin
      pre_d = 16'd0;
      cnt_d = '0;
      sat_d = 1'b0;
    end

    if ((state_q == ST_MEDE_ALTO) && fall) begin
      alto_d     = cnt_q;
      sat_alto_d = sat_q;
    end

    if ((state_q == ST_MEDE_BAIXO) && rise) begin
      tempo_d     = alto_q;
      intervalo_d = cnt_q;
      estouro_d   = sat_alto_q | sat_q;
      valido_d    = 1'b1;
    end
  end

`ifdef MEDIDOR_TIMEOUT_EN
  logic sem_sinal_q, sem_sinal_d;

  always_comb begin
    sem_sinal_d = sem_sinal_q;
    if (timeout)   sem_sinal_d = 1'b1;
    else if (rise) sem_sinal_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sem_sinal_q <= 1'b0;
    else        sem_sinal_q <= sem_sinal_d;
  end

  assign sem_sinal = sem_sinal_q;
`else
  assign sem_sinal = 1'b0;
`endif

  assign tempo_medido     = tempo_q;
  assign intervalo_medido = intervalo_q;
  assign valido           = valido_q;
  assign estouro          = estouro_q;

endmodule
`default_nettype wire

// File: tb/tb_medidor_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_medidor_timer
// Purpose  : Directed, table-driven checks of medidor_timer with CLK_DIV=4, W=5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_medidor_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       entrada;
  logic [4:0] tempo_medido;
  logic [4:0] intervalo_medido;
  logic       valido;
  logic       estouro;
  logic       sem_sinal;

  medidor_timer #(.CLK_DIV(4), .W(5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .entrada          (entrada),
    .tempo_medido     (tempo_medido),
    .intervalo_medido (intervalo_medido),
    .valido           (valido),
    .estouro          (estouro),
    .sem_sinal        (sem_sinal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hi;
    int lo;
    int t;
    int iv;
    int ov;
  } vec_t;

  vec_t vecs[10];
  int   n_pass  = 0;
  int   n_total = 0;

  int nv, vt, vi, ve, vj, sj;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drive entrada to lvl for n cycles, recording strobes and sem_sinal onset.
  task automatic phase(input logic lvl, input int n);
    entrada = lvl;
    nv = 0; vj = 0; sj = 0;
    for (int j = 1; j <= n; j++) begin
      @(posedge clk); #1;
      if (valido) begin
        nv++;
        vj = j;
        vt = int'(tempo_medido);
        vi = int'(intervalo_medido);
        ve = int'(estouro);
      end
      if (sem_sinal && sj == 0) sj = j;
    end
  endtask

  task automatic chk_report(input string name, input int t, input int iv, input int ov);
    chk({name, " valido count"}, nv, 1);
    chk({name, " valido latency"}, vj, 3);
    chk({name, " tempo"}, vt, t);
    chk({name, " intervalo"}, vi, iv);
    chk({name, " estouro"}, ve, ov);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " tempo"}, int'(tempo_medido), 0);
    chk({name, " intervalo"}, int'(intervalo_medido), 0);
    chk({name, " valido"}, int'(valido), 0);
    chk({name, " estouro"}, int'(estouro), 0);
    chk({name, " sem_sinal"}, int'(sem_sinal), 0);
  endtask

  initial begin
    vecs[0] = '{hi: 12,  lo: 20,  t: 3,  iv: 5,  ov: 0};
    vecs[1] = '{hi: 12,  lo: 20,  t: 3,  iv: 5,  ov: 0};
    vecs[2] = '{hi: 8,   lo: 8,   t: 2,  iv: 2,  ov: 0};
`ifdef MEDIDOR_TIMEOUT_EN
    vecs[3] = '{hi: 12,  lo: 120, t: 3,  iv: 30, ov: 0};
`else
    vecs[3] = '{hi: 12,  lo: 200, t: 3,  iv: 31, ov: 1};
`endif
    vecs[4] = '{hi: 12,  lo: 20,  t: 3,  iv: 5,  ov: 0};
    vecs[5] = '{hi: 3,   lo: 6,   t: 0,  iv: 1,  ov: 0};
    vecs[6] = '{hi: 5,   lo: 7,   t: 1,  iv: 1,  ov: 0};
    vecs[7] = '{hi: 124, lo: 8,   t: 31, iv: 2,  ov: 0};
    vecs[8] = '{hi: 128, lo: 4,   t: 31, iv: 1,  ov: 1};
    vecs[9] = '{hi: 4,   lo: 3,   t: 1,  iv: 0,  ov: 0};

    rst_n   = 1'b0;
    entrada = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    phase(1'b0, 40);
    chk("idle low valido count", nv, 0);

    for (int i = 0; i < 10; i++) begin
      phase(1'b1, vecs[i].hi);
      if (i == 0) chk("first rise valido count", nv, 0);
      else chk_report($sformatf("vec%0d", i - 1), vecs[i-1].t, vecs[i-1].iv, vecs[i-1].ov);
      phase(1'b0, vecs[i].lo);
      chk($sformatf("vec%0d low valido count", i), nv, 0);
      chk($sformatf("vec%0d sem_sinal", i), int'(sem_sinal), 0);
    end
    phase(1'b1, 8);
    chk_report("vec9", vecs[9].t, vecs[9].iv, vecs[9].ov);

    // Reset pulse in the middle of a high phase with the line held high.
    phase(1'b1, 4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("mid reset");
    rst_n = 1'b1;
    phase(1'b1, 8);
    chk("post reset high valido count", nv, 0);
    phase(1'b0, 12);
    chk("post reset low valido count", nv, 0);
    phase(1'b1, 8);
    chk("post reset first rise valido count", nv, 0);
    phase(1'b0, 8);
    phase(1'b1, 8);
    chk_report("post reset", 2, 2, 0);

`ifdef MEDIDOR_TIMEOUT_EN
    phase(1'b0, 8);
    phase(1'b1, 200);
    chk("timeout valido count", nv, 0);
    chk("timeout sem_sinal onset", sj, 134);
    chk("timeout sem_sinal held", int'(sem_sinal), 1);
    phase(1'b0, 8);
    chk("timeout fall ignored valido", nv, 0);
    chk("timeout sem_sinal after fall", int'(sem_sinal), 1);
    phase(1'b1, 8);
    chk("timeout rise valido count", nv, 0);
    chk("timeout sem_sinal cleared", int'(sem_sinal), 0);
    phase(1'b0, 8);
    phase(1'b1, 8);
    chk_report("after timeout", 2, 2, 0);
`else
    phase(1'b0, 8);
    phase(1'b1, 200);
    chk("long high sem_sinal", int'(sem_sinal), 0);
    phase(1'b0, 8);
    phase(1'b1, 8);
    chk_report("long high", 31, 2, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/medidor_timer.md
Name: medidor_timer

Overview:
- Measures a periodic on/off pulse train in time ticks of CLK_DIV clk cycles: high-phase length (on time) and low-phase length (interval).
- Sits at the receiving end of a timer-controlled output line, so firmware or self-test logic can check programmed interval and on-time values against the real signal.
- Publishes one result pair per complete period, with a one-cycle valid strobe.

Parameters:
- CLK_DIV, 1000: clk cycles per measurement tick; legal range 2..65535.
- W, 5: width of the tick counters and result fields.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- entrada  in  1  measured pulse line, asynchronous to clk
- tempo_medido  out  W  ticks in the last complete high phase
- intervalo_medido  out  W  ticks in the last complete low phase
- valido  out  1  one-cycle strobe: new result pair present
- estouro  out  1  last reported pair had a saturated field
- sem_sinal  out  1  line stuck, see Optional Feature

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values on a clk edge with rst_n=0:
  - all outputs 0; state ESPERA; counters 0.
  - both synchronizer flops and the edge-history flop load 1. A line that is high at reset release therefore produces no false rising edge.
- Input path: 2-flop synchronizer, then a history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Edge detect happens 3 clk edges after entrada changes, if setup is met.
- Prescaler: 16-bit counter, 0..CLK_DIV-1, forced to 0 on every detected edge.
  - On wrap (value CLK_DIV-1), tick=1 for one cycle.
  - Phase count = number of full CLK_DIV-cycle intervals since the last edge (floor).
- Phase counter cnt (W bits):
  - cleared on every edge.
  - +1 on tick.
  - saturates at 2^W-1; further ticks set a sticky sat bit, which is cleared on every edge.
- FSM states: ESPERA, MEDE_ALTO, MEDE_BAIXO.
  - ESPERA: ignores fall; counters idle. On rise -> MEDE_ALTO.
  - MEDE_ALTO, on fall: latch alto_reg=cnt and sat_alto=sat; -> MEDE_BAIXO.
  - MEDE_BAIXO, on rise:
    - tempo_medido<=alto_reg; intervalo_medido<=cnt.
    - estouro<=sat_alto|sat; valido<=1 for exactly one cycle.
    - -> MEDE_ALTO.
- The first report needs a full high phase and a full low phase after leaving ESPERA. The partial phase before the first rise is never reported.
- Result registers hold until the next report. valido is 0 in all other cycles.
- A phase shorter than CLK_DIV cycles reports 0.
- Edge and tick in the same cycle: the edge wins (cnt cleared, tick ignored).
- rst_n low mid-measurement: all in-flight counts are discarded, the FSM returns to ESPERA, and outputs clear on the same edge.

Optional Feature:
- Macro: MEDIDOR_TIMEOUT_EN.
- Defined:
  - In MEDE_ALTO or MEDE_BAIXO, a tick while cnt is already saturated and sat is set means no edge for 2^W+1 ticks.
  - The FSM then goes to ESPERA and sets sem_sinal=1.
  - sem_sinal clears on the next rise.
  - No report is issued for the aborted period.
- Not defined:
  - sem_sinal is tied to 0.
  - The FSM waits indefinitely; counts stay saturated and are reported with estouro=1 at the next rise.

Test Plan:
- CLK_DIV=4. After reset, entrada low 40 cycles, then repeated high 12 / low 20 cycles -> first valido at the 2nd rise + 3 cycles; tempo_medido=3, intervalo_medido=5, estouro=0; repeats every period.
- CLK_DIV=4. entrada held high through reset release for 30 cycles, then low 8 / high 8 -> no valido before the first genuine rise; reports 2/2.
- CLK_DIV=4, W=5. High 12 cycles, low 200 cycles -> intervalo_medido=31, estouro=1, tempo_medido=3. A following normal period reports estouro=0.
- CLK_DIV=4. High 3 cycles, low 6 cycles -> tempo_medido=0, intervalo_medido=1.
- rst_n pulsed low for 1 cycle mid high phase -> next cycle all outputs 0, state ESPERA; the next report needs a fresh full high+low after a new rise.
- With MEDIDOR_TIMEOUT_EN, CLK_DIV=4, W=5. entrada held high for 200 cycles after the first rise -> sem_sinal=1 once 33 ticks pass with no edge, no valido. On the next rise, sem_sinal=0 and measurement restarts.
